// File: rtl/flag_stack_reg.sv
// Status-flag register with masked load/set/clear/toggle and a LIFO save stack
// for interrupt entry/return; overflow/underflow are latched as sticky errors.
module flag_stack_reg #(
    parameter int NFLAGS = 4,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        op,
    input  logic [NFLAGS-1:0] flags_in,
    input  logic [NFLAGS-1:0] mask,
    output logic [NFLAGS-1:0] flags,
    output logic [CW-1:0]     level,
    output logic              full,
    output logic              empty,
    output logic              ovf_err,
    output logic              unf_err
);

    typedef enum logic [2:0] {
        OP_HOLD   = 3'b000,
        OP_LOAD   = 3'b001,
        OP_CLEAR  = 3'b010,
        OP_SET    = 3'b011,
        OP_PUSH   = 3'b100,
        OP_POP    = 3'b101,
        OP_TOGGLE = 3'b110,
        OP_RSVD   = 3'b111
    } op_t;

    op_t op_sel;
    assign op_sel = op_t'(op);

    logic [NFLAGS-1:0] flags_reg, flags_next;
    logic [CW-1:0]     level_reg, level_next;
    logic              ovf_reg, unf_reg;
    logic [NFLAGS-1:0] stack_reg [DEPTH];
    logic [NFLAGS-1:0] pop_data;
    logic              full_w, empty_w, push_ok, pop_ok;

    assign full_w  = (level_reg == CW'(DEPTH));
    assign empty_w = (level_reg == '0);
    assign push_ok = (op_sel == OP_PUSH) && !full_w;
    assign pop_ok  = (op_sel == OP_POP) && !empty_w;

    // Top-of-stack entry is the one just below level.
    always_comb begin
        pop_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (level_reg == CW'(i + 1)) begin
                pop_data = stack_reg[i];
            end
        end
    end

    always_comb begin
        flags_next = flags_reg;
        level_next = level_reg;
        case (op_sel)
            OP_LOAD:   flags_next = (flags_reg & ~mask) | (flags_in & mask);
            OP_CLEAR:  flags_next = flags_reg & ~mask;
            OP_SET:    flags_next = flags_reg | mask;
            OP_TOGGLE: flags_next = flags_reg ^ mask;
            OP_PUSH: begin
                if (push_ok) begin
                    level_next = level_reg + CW'(1);
                end
            end
            OP_POP: begin
                if (pop_ok) begin
                    flags_next = pop_data;
                    level_next = level_reg - CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_reg <= '0;
            level_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_reg[i] <= '0;
            end
        end else begin
            flags_reg <= flags_next;
            level_reg <= level_next;
            if ((op_sel == OP_PUSH) && full_w) begin
                ovf_reg <= 1'b1;
            end
            if ((op_sel == OP_POP) && empty_w) begin
                unf_reg <= 1'b1;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push_ok && (level_reg == CW'(i))) begin
                    stack_reg[i] <= flags_reg;
                end
            end
        end
    end

    assign flags   = flags_reg;
    assign level   = level_reg;
    assign full    = full_w;
    assign empty   = empty_w;
    assign ovf_err = ovf_reg;
    assign unf_err = unf_reg;

endmodule

// File: tb/tb_flag_stack_reg.sv
// Bench for flag_stack_reg: two instances (4 flags/depth 4, 8 flags/depth 1)
// checked against a queue-based reference model under directed and random ops.
module tb_flag_stack_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [2:0] op_a, op_b;
    logic [3:0] fin_a, mask_a, flags_a;
    logic [2:0] level_a;
    logic       full_a, empty_a, ovf_a, unf_a;
    logic [7:0] fin_b, mask_b, flags_b;
    logic [0:0] level_b;
    logic       full_b, empty_b, ovf_b, unf_b;

    flag_stack_reg #(.NFLAGS(4), .DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .op(op_a), .flags_in(fin_a), .mask(mask_a),
        .flags(flags_a), .level(level_a), .full(full_a), .empty(empty_a),
        .ovf_err(ovf_a), .unf_err(unf_a)
    );

    flag_stack_reg #(.NFLAGS(8), .DEPTH(1)) dut_b (
        .clk(clk), .reset(reset), .op(op_b), .flags_in(fin_b), .mask(mask_b),
        .flags(flags_b), .level(level_b), .full(full_b), .empty(empty_b),
        .ovf_err(ovf_b), .unf_err(unf_b)
    );

    // Reference model: flag word, a queue as the save stack, sticky errors.
    int         cur;
    int         m_depth;
    logic [7:0] m_wmask;
    logic [7:0] m_flags;
    logic [7:0] m_stack[$];
    logic       m_ovf, m_unf;
    int         total = 0;
    int         bad = 0;

    task automatic model_reset();
        m_flags = '0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_apply(input logic [2:0] o, input logic [7:0] fin, input logic [7:0] msk);
        logic [7:0] f, m;
        f = fin & m_wmask;
        m = msk & m_wmask;
        case (o)
            3'd1: for (int b = 0; b < 8; b++) if (m[b]) m_flags[b] = f[b];
            3'd2: for (int b = 0; b < 8; b++) if (m[b]) m_flags[b] = 1'b0;
            3'd3: for (int b = 0; b < 8; b++) if (m[b]) m_flags[b] = 1'b1;
            3'd6: for (int b = 0; b < 8; b++) if (m[b]) m_flags[b] = ~m_flags[b];
            3'd4: begin
                if (m_stack.size() == m_depth) m_ovf = 1'b1;
                else m_stack.push_back(m_flags);
            end
            3'd5: begin
                if (m_stack.size() == 0) m_unf = 1'b1;
                else m_flags = m_stack.pop_back();
            end
            default: ;
        endcase
    endtask

    task automatic observe(output logic [7:0] of, output int ol, output logic ofu,
                           output logic oem, output logic oov, output logic oun);
        if (cur == 0) begin
            of = {4'b0, flags_a}; ol = int'(level_a);
            ofu = full_a; oem = empty_a; oov = ovf_a; oun = unf_a;
        end else begin
            of = flags_b; ol = int'(level_b);
            ofu = full_b; oem = empty_b; oov = ovf_b; oun = unf_b;
        end
    endtask

    task automatic check(input string tag);
        logic [7:0] of;
        int         ol;
        logic       ofu, oem, oov, oun, efu, eem;
        observe(of, ol, ofu, oem, oov, oun);
        efu = (m_stack.size() == m_depth);
        eem = (m_stack.size() == 0);
        total++;
        assert (of === m_flags) else begin
            bad++; $error("FAIL %s flags got=%h want=%h", tag, of, m_flags);
        end
        total++;
        assert (ol === m_stack.size()) else begin
            bad++; $error("FAIL %s level got=%0d want=%0d", tag, ol, m_stack.size());
        end
        total++;
        assert (ofu === efu) else begin
            bad++; $error("FAIL %s full got=%b want=%b", tag, ofu, efu);
        end
        total++;
        assert (oem === eem) else begin
            bad++; $error("FAIL %s empty got=%b want=%b", tag, oem, eem);
        end
        total++;
        assert (oov === m_ovf) else begin
            bad++; $error("FAIL %s ovf_err got=%b want=%b", tag, oov, m_ovf);
        end
        total++;
        assert (oun === m_unf) else begin
            bad++; $error("FAIL %s unf_err got=%b want=%b", tag, oun, m_unf);
        end
        $display("[%0t] unit%0d %s flags=%h level=%0d", $time, cur, tag, of, ol);
    endtask

    // Directed expectation straight from the test plan, independent of the model.
    task automatic expect_flags(input logic [7:0] v, input string tag);
        logic [7:0] of;
        int         ol;
        logic       ofu, oem, oov, oun;
        observe(of, ol, ofu, oem, oov, oun);
        total++;
        assert (of === v) else begin
            bad++; $error("FAIL %s direct flags got=%h want=%h", tag, of, v);
        end
    endtask

    task automatic expect_status(input int lvl, input logic fu, input logic ov, input logic un,
                                 input string tag);
        logic [7:0] of;
        int         ol;
        logic       ofu, oem, oov, oun;
        observe(of, ol, ofu, oem, oov, oun);
        total++;
        assert (ol === lvl && ofu === fu && oov === ov && oun === un) else begin
            bad++;
            $error("FAIL %s direct status got lvl=%0d full=%b ovf=%b unf=%b want lvl=%0d full=%b ovf=%b unf=%b",
                   tag, ol, ofu, oov, oun, lvl, fu, ov, un);
        end
    endtask

    task automatic step(input logic [2:0] o, input logic [7:0] fin, input logic [7:0] msk,
                        input string tag);
        @(negedge clk);
        if (cur == 0) begin
            op_a = o; fin_a = fin[3:0]; mask_a = msk[3:0];
        end else begin
            op_b = o; fin_b = fin; mask_b = msk;
        end
        @(posedge clk);
        #1;
        if (!reset) model_apply(o, fin, msk);
        op_a = 3'd0;
        op_b = 3'd0;
        check(tag);
    endtask

    task automatic async_reset_pulse(input string tag);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check(tag);
        // An op presented while reset is high must be ignored.
        @(negedge clk);
        op_a = 3'd1; fin_a = 4'hF; mask_a = 4'hF;
        op_b = 3'd1; fin_b = 8'hFF; mask_b = 8'hFF;
        @(posedge clk);
        #1;
        check({tag, "_held"});
        @(negedge clk);
        reset = 1'b0;
        op_a = 3'd0;
        op_b = 3'd0;
    endtask

    task automatic random_ops(input int n);
        for (int i = 0; i < n; i++) begin
            step(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), "rand");
        end
    endtask

    initial begin
        reset = 1'b1;
        op_a = '0; fin_a = '0; mask_a = '0;
        op_b = '0; fin_b = '0; mask_b = '0;
        cur = 0; m_depth = 4; m_wmask = 8'h0F;
        model_reset();
        #12;
        check("reset");
        @(negedge clk);
        reset = 1'b0;

        step(3'd1, 8'h6, 8'hF, "pre_load");
        async_reset_pulse("async_rst");

        // Masked ops
        step(3'd1, 8'hB, 8'hF, "load_1011");   expect_flags(8'h0B, "load_1011");
        step(3'd3, 8'h0, 8'h4, "set_0100");    expect_flags(8'h0F, "set_0100");
        step(3'd2, 8'h0, 8'h3, "clr_0011");    expect_flags(8'h0C, "clr_0011");
        step(3'd6, 8'h0, 8'h9, "tgl_1001");    expect_flags(8'h05, "tgl_1001");
        step(3'd1, 8'h0, 8'h1, "load_m0001");  expect_flags(8'h04, "load_m0001");

        // Nesting: 0001,0010,0100,1000 pushed in order
        for (int k = 0; k < 4; k++) begin
            step(3'd1, 8'(1 << k), 8'hF, "nest_load");
            step(3'd4, 8'hA, 8'hF, "nest_push");
        end
        expect_status(4, 1'b1, 1'b0, 1'b0, "nest_full");
        step(3'd1, 8'h0, 8'hF, "nest_clear");
        for (int k = 3; k >= 0; k--) begin
            step(3'd5, 8'h0, 8'h0, "nest_pop");
            expect_flags(8'(1 << k), "nest_pop");
        end
        expect_status(0, 1'b0, 1'b0, 1'b0, "nest_empty");

        // Overflow
        for (int k = 0; k < 4; k++) step(3'd4, 8'h0, 8'h0, "fill");
        step(3'd4, 8'h0, 8'h0, "ovf_push");
        expect_status(4, 1'b1, 1'b1, 1'b0, "ovf_push");
        step(3'd5, 8'h0, 8'h0, "ovf_pop");
        expect_status(3, 1'b0, 1'b1, 1'b0, "ovf_sticky");
        for (int k = 0; k < 3; k++) step(3'd5, 8'h0, 8'h0, "drain");

        // Underflow, then a normal push/pop pair
        step(3'd1, 8'h9, 8'hF, "unf_load");
        step(3'd5, 8'h0, 8'h0, "unf_pop");
        expect_status(0, 1'b0, 1'b1, 1'b1, "unf_pop");
        expect_flags(8'h09, "unf_keep");
        step(3'd4, 8'h0, 8'h0, "unf_push");
        step(3'd1, 8'h2, 8'hF, "push_then_load");
        step(3'd5, 8'h0, 8'h0, "unf_pop2");
        expect_flags(8'h09, "pre_load_copy");

        // Back-to-back push/pop
        step(3'd4, 8'h0, 8'h0, "b2b_push1");
        step(3'd5, 8'h0, 8'h0, "b2b_pop1");
        step(3'd4, 8'h0, 8'h0, "b2b_push2");
        step(3'd5, 8'h0, 8'h0, "b2b_pop2");
        expect_flags(8'h09, "b2b_end");
        step(3'd7, 8'hF, 8'hF, "reserved");

        random_ops(200);
        async_reset_pulse("async_rst_mid");
        random_ops(100);

        // Parametrisation: NFLAGS=8, DEPTH=1
        cur = 1; m_depth = 1; m_wmask = 8'hFF;
        async_reset_pulse("b_rst");
        step(3'd1, 8'hA5, 8'hFF, "b_load");
        step(3'd4, 8'h0, 8'h0, "b_push");
        expect_status(1, 1'b1, 1'b0, 1'b0, "b_full");
        step(3'd1, 8'h3C, 8'hFF, "b_load2");
        step(3'd4, 8'h0, 8'h0, "b_ovf");
        expect_status(1, 1'b1, 1'b1, 1'b0, "b_ovf");
        step(3'd5, 8'h0, 8'h0, "b_pop");
        expect_flags(8'hA5, "b_pop");
        random_ops(150);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
